// File: rtl/ifm_buf_loader.sv
// IFM line-buffer preloader: fetches one frame row per request and writes it into the selected buffer.
// Optional IFM_LOADER_STAT_EN adds o_stall_cnt (REQ/XFER wait cycles); 1-cycle request latency, done 2 cycles after last beat.
module ifm_buf_loader #(
  parameter int W_SIZE      = 8,
  parameter int W_CHANNEL   = 6,
  parameter int IFM_BUF_CNT = 4,
  parameter int W_IFM_BUF   = 2,
  parameter int W_DATA      = 64,
  parameter int W_ADDR      = 32,
  parameter int W_BUF_ADDR  = 12
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          q_start,
  input  logic [W_SIZE-1:0]             q_width,
  input  logic [W_CHANNEL-1:0]          q_channel,
  input  logic [W_ADDR-1:0]             q_base_addr,
  input  logic [IFM_BUF_CNT-1:0]        i_load_start,
  input  logic [W_SIZE-1:0]             i_load_row,
  output logic                          o_rd_req,
  output logic [W_ADDR-1:0]             o_rd_addr,
  output logic [W_SIZE+W_CHANNEL-1:0]   o_rd_len,
  input  logic                          i_rd_ack,
  input  logic [W_DATA-1:0]             i_rd_data,
  input  logic                          i_rd_valid,
  output logic                          o_rd_ready,
  output logic [IFM_BUF_CNT-1:0]        o_buf_we,
  output logic [W_BUF_ADDR-1:0]         o_buf_addr,
  output logic [W_DATA-1:0]             o_buf_wdata,
  output logic [IFM_BUF_CNT-1:0]        o_ifm_buf_done,
  output logic                          o_busy,
`ifdef IFM_LOADER_STAT_EN
  output logic [31:0]                   o_stall_cnt,
`endif
  output logic                          o_overrun
);

  localparam int W_LEN = W_SIZE + W_CHANNEL;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  function automatic logic [IFM_BUF_CNT-1:0] id2oh(input logic [W_IFM_BUF-1:0] id);
    id2oh     = '0;
    id2oh[id] = 1'b1;
  endfunction

  // Request decode: lowest set bit wins, q_start overrides with (buffer 0, row 0)
  logic [W_IFM_BUF-1:0] req_id;
  logic                 req_any;
  logic [W_LEN-1:0]     words_per_row;
  logic [W_ADDR-1:0]    row_addr;
  logic                 acc_vld;
  logic [W_IFM_BUF-1:0] acc_id;
  logic [W_ADDR-1:0]    acc_addr;

  always_comb begin
    req_id = '0;
    for (int i = IFM_BUF_CNT - 1; i >= 0; i--) begin
      if (i_load_start[i]) req_id = W_IFM_BUF'(i);
    end
  end

  assign req_any       = |i_load_start;
  assign words_per_row = W_LEN'(q_width) * W_LEN'(q_channel);
  assign row_addr      = q_base_addr + W_ADDR'(i_load_row) * W_ADDR'(words_per_row);
  assign acc_vld       = q_start | req_any;
  assign acc_id        = q_start ? '0 : req_id;
  assign acc_addr      = q_start ? q_base_addr : row_addr;

  // Active and pending slots
  logic [W_IFM_BUF-1:0] act_id,   pend_id;
  logic [W_ADDR-1:0]    act_addr, pend_addr;
  logic [W_LEN-1:0]     act_len,  pend_len;
  logic                 pend_vld;

  logic                 pend_live;
  logic                 promote;
  logic                 to_act;
  logic                 to_pend;
  logic                 drop;
  logic                 load_act;
  logic [W_IFM_BUF-1:0] src_id;
  logic [W_ADDR-1:0]    src_addr;
  logic [W_LEN-1:0]     src_len;

  // A pending entry is promoted whenever the engine is free; that frees the slot for a same-cycle request
  assign pend_live = pend_vld & ~q_start;
  assign promote   = pend_live & ((state == ST_IDLE) | (state == ST_DONE));
  assign to_act    = acc_vld & (state == ST_IDLE) & ~pend_live;
  assign to_pend   = acc_vld & ~to_act & (~pend_live | promote);
  assign drop      = (acc_vld & ~to_act & ~to_pend) | (q_start & req_any);
  assign load_act  = to_act | promote;
  assign src_id    = promote ? pend_id   : acc_id;
  assign src_addr  = promote ? pend_addr : acc_addr;
  assign src_len   = promote ? pend_len  : words_per_row;

  logic [W_LEN-1:0] wcnt;
  logic             beat;
  logic             last_beat;

  assign beat      = (state == ST_XFER) & i_rd_valid;
  assign last_beat = beat & (wcnt == act_len - W_LEN'(1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (load_act) state_nxt = (src_len == '0) ? ST_DONE : ST_REQ;
      ST_REQ:  if (i_rd_ack) state_nxt = ST_XFER;
      ST_XFER: if (last_beat) state_nxt = ST_DONE;
      ST_DONE: begin
        if (load_act) state_nxt = (src_len == '0) ? ST_DONE : ST_REQ;
        else          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_rd_req   = (state == ST_REQ);
    o_rd_ready = (state == ST_XFER);
    o_busy     = (state != ST_IDLE);
  end

  assign o_rd_addr = act_addr;
  assign o_rd_len  = act_len;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      act_id    <= '0;
      act_addr  <= '0;
      act_len   <= '0;
      pend_vld  <= 1'b0;
      pend_id   <= '0;
      pend_addr <= '0;
      pend_len  <= '0;
    end else begin
      if (load_act) begin
        act_id   <= src_id;
        act_addr <= src_addr;
        act_len  <= src_len;
      end
      if (to_pend) begin
        pend_vld  <= 1'b1;
        pend_id   <= acc_id;
        pend_addr <= acc_addr;
        pend_len  <= words_per_row;
      end else if (promote || q_start) begin
        pend_vld  <= 1'b0;
      end
    end
  end

  // Write port is registered, so each accepted beat lands in the buffer one cycle later
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wcnt        <= '0;
      o_buf_we    <= '0;
      o_buf_addr  <= '0;
      o_buf_wdata <= '0;
    end else begin
      if (state == ST_REQ) wcnt <= '0;
      else if (beat)       wcnt <= wcnt + W_LEN'(1);
      o_buf_we <= beat ? id2oh(act_id) : '0;
      if (beat) begin
        o_buf_addr  <= W_BUF_ADDR'(wcnt);
        o_buf_wdata <= i_rd_data;
      end
    end
  end

  logic [IFM_BUF_CNT-1:0] done_set;
  logic [IFM_BUF_CNT-1:0] done_clr;

  assign done_set = (state == ST_DONE) ? id2oh(act_id) : '0;
  assign done_clr = (to_act | to_pend) ? id2oh(acc_id) : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_ifm_buf_done <= '0;
      o_overrun      <= 1'b0;
    end else begin
      if (q_start) o_ifm_buf_done <= '0;
      else         o_ifm_buf_done <= (o_ifm_buf_done | done_set) & ~done_clr;
      if (drop)         o_overrun <= 1'b1;
      else if (q_start) o_overrun <= 1'b0;
    end
  end

`ifdef IFM_LOADER_STAT_EN
  logic stall;
  assign stall = ((state == ST_REQ) & ~i_rd_ack) | ((state == ST_XFER) & ~i_rd_valid);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                        o_stall_cnt <= '0;
    else if (q_start)                 o_stall_cnt <= '0;
    else if (stall && ~&o_stall_cnt)  o_stall_cnt <= o_stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_ifm_buf_loader.sv
// Randomized bench for ifm_buf_loader: memory responder, transaction-level scoreboard and directed corner cases.
module tb_ifm_buf_loader;

  logic        clk = 1'b0;
  logic        rstn;
  logic        q_start;
  logic [7:0]  q_width;
  logic [5:0]  q_channel;
  logic [31:0] q_base_addr;
  logic [3:0]  i_load_start;
  logic [7:0]  i_load_row;
  logic        o_rd_req;
  logic [31:0] o_rd_addr;
  logic [13:0] o_rd_len;
  logic        i_rd_ack;
  logic [63:0] i_rd_data;
  logic        i_rd_valid;
  logic        o_rd_ready;
  logic [3:0]  o_buf_we;
  logic [11:0] o_buf_addr;
  logic [63:0] o_buf_wdata;
  logic [3:0]  o_ifm_buf_done;
  logic        o_busy;
  logic        o_overrun;
`ifdef IFM_LOADER_STAT_EN
  logic [31:0] o_stall_cnt;
`endif

  ifm_buf_loader dut (
    .clk(clk), .rstn(rstn), .q_start(q_start), .q_width(q_width), .q_channel(q_channel),
    .q_base_addr(q_base_addr), .i_load_start(i_load_start), .i_load_row(i_load_row),
    .o_rd_req(o_rd_req), .o_rd_addr(o_rd_addr), .o_rd_len(o_rd_len), .i_rd_ack(i_rd_ack),
    .i_rd_data(i_rd_data), .i_rd_valid(i_rd_valid), .o_rd_ready(o_rd_ready),
    .o_buf_we(o_buf_we), .o_buf_addr(o_buf_addr), .o_buf_wdata(o_buf_wdata),
    .o_ifm_buf_done(o_ifm_buf_done), .o_busy(o_busy),
`ifdef IFM_LOADER_STAT_EN
    .o_stall_cnt(o_stall_cnt),
`endif
    .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Behavioural model: every accepted load turns into one burst and a row of writes
  typedef struct { logic [31:0] addr; logic [13:0] len; } rd_t;
  typedef struct { logic [3:0] we; logic [11:0] addr; logic [63:0] data; } wr_t;
  rd_t        exp_rd[$];
  wr_t        exp_wr[$];
  logic [3:0] exp_done = '0;
  logic       exp_ovr  = 1'b0;
  int         stall_exp = 0;
  bit         toggle_mode = 1'b0;

  function automatic logic [63:0] beat_data(input logic [31:0] a, input int k);
    return {a + 32'(k), 32'hC0DE_0000 ^ 32'(k)};
  endfunction

  task automatic model_accept(input int id, input int row);
    int          wpr;
    logic [31:0] a;
    rd_t         r;
    wr_t         w;
    wpr = int'(q_width) * int'(q_channel);
    a   = q_base_addr + 32'(row) * 32'(wpr);
    if (wpr != 0) begin
      r.addr = a; r.len = 14'(wpr);
      exp_rd.push_back(r);
      for (int k = 0; k < wpr; k++) begin
        w.we = 4'(1 << id); w.addr = 12'(k); w.data = beat_data(a, k);
        exp_wr.push_back(w);
      end
    end
    exp_done[id] = 1'b1;
  endtask

  // Memory responder: random ack delay, random (or alternating) valid gaps
  initial begin
    bit          rb = 1'b0;
    logic [31:0] raddr = '0;
    int          rlen = 0;
    int          k = 0;
    bit          tog = 1'b0;
    i_rd_ack = 1'b0; i_rd_valid = 1'b0; i_rd_data = '0;
    forever begin
      @(negedge clk);
      i_rd_ack = 1'b0;
      if (!rstn) begin
        rb = 1'b0; i_rd_valid = 1'b0; stall_exp = 0;
      end else if (!rb) begin
        i_rd_valid = 1'b0;
        if (o_rd_req) begin
          if (toggle_mode || $urandom_range(0, 2) == 0) begin
            i_rd_ack = 1'b1; rb = 1'b1; raddr = o_rd_addr; rlen = int'(o_rd_len); k = 0; tog = 1'b0;
          end else begin
            stall_exp++;
          end
        end
      end else begin
        if (toggle_mode) begin tog = ~tog; i_rd_valid = tog; end
        else i_rd_valid = ($urandom_range(0, 3) != 0);
        i_rd_data = beat_data(raddr, k);
        if (o_rd_ready && !i_rd_valid) stall_exp++;
        if (i_rd_valid && o_rd_ready) begin
          k++;
          if (k == rlen) rb = 1'b0;
        end
      end
    end
  end

  // Scoreboard: burst requests and buffer writes against the model queues
  initial begin
    wr_t w;
    rd_t r;
    forever begin
      @(negedge clk);
      #1;
      if (rstn) begin
        if (o_buf_we != '0) begin
          if (exp_wr.size() == 0) chk("unexpected_write", {o_buf_we, o_buf_addr}, '0);
          else begin
            w = exp_wr.pop_front();
            chk("buf_write", {o_buf_we, o_buf_addr, o_buf_wdata}, {w.we, w.addr, w.data});
          end
        end
        if (o_rd_req && i_rd_ack) begin
          if (exp_rd.size() == 0) chk("unexpected_rd_req", {o_rd_addr, o_rd_len}, '0);
          else begin
            r = exp_rd.pop_front();
            chk("rd_req", {o_rd_addr, o_rd_len}, {r.addr, r.len});
          end
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    q_start = 1'b1;
    if (i_load_start != '0) exp_ovr = 1'b1; else exp_ovr = 1'b0;
    stall_exp = 0;
    exp_done  = '0;
    model_accept(0, 0);
    @(negedge clk);
    q_start = 1'b0;
  endtask

  task automatic req_cycle(input int id, input int row);
    @(negedge clk);
    i_load_start = 4'(1 << id);
    i_load_row   = 8'(row);
  endtask

  task automatic req_end();
    @(negedge clk);
    i_load_start = '0;
  endtask

  task automatic wait_idle();
    int quiet = 0;
    int n = 0;
    while (quiet < 2 && n < 3000) begin
      @(negedge clk);
      n++;
      if (!o_busy) quiet++; else quiet = 0;
    end
    if (n >= 3000) chk("wait_idle_timeout", 1, 0);
    #2;
  endtask

  task automatic check_idle_state(input string tag);
    chk({tag, "_done"}, o_ifm_buf_done, exp_done);
    chk({tag, "_overrun"}, o_overrun, exp_ovr);
`ifdef IFM_LOADER_STAT_EN
    chk({tag, "_stall"}, o_stall_cnt, 32'(stall_exp));
`endif
  endtask

  initial begin
    int n;
    int bad;
    rstn = 1'b0; q_start = 1'b0; q_width = '0; q_channel = '0; q_base_addr = '0;
    i_load_start = '0; i_load_row = '0;
    #1;
    chk("reset_outputs", {o_rd_req, o_buf_we, o_ifm_buf_done, o_busy, o_overrun, o_rd_ready, o_rd_addr},
        '0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // Frame start: row 0 of a 4x2 frame at 0x100 into buffer 0
    q_width = 8'd4; q_channel = 6'd2; q_base_addr = 32'h100;
    pulse_start();
    chk("start_req_latency", o_rd_req, 1'b1);
    chk("start_req_addr_len", {o_rd_addr, o_rd_len}, {32'h100, 14'd8});
    n = 0;
    while (!(o_buf_we[0] && o_buf_addr == 12'd7) && n < 200) begin @(negedge clk); n++; end
    chk("last_write_seen", n < 200, 1'b1);
    chk("done_not_yet_at_last_write", o_ifm_buf_done, 4'b0000);
    @(negedge clk);
    chk("done_two_after_last_beat", o_ifm_buf_done, 4'b0001);
    wait_idle();
    check_idle_state("start");

    // Row 1 into buffer 1
    req_cycle(1, 1); model_accept(1, 1);
    req_end();
    chk("row1_addr", {o_rd_req, o_rd_addr}, {1'b1, 32'h108});
    chk("row1_done0_kept", o_ifm_buf_done, 4'b0001);
    wait_idle();
    chk("row1_done_literal", o_ifm_buf_done, 4'b0011);
    check_idle_state("row1");

    // Three back-to-back requests: active, pending, dropped
    req_cycle(1, 2); model_accept(1, 2);
    req_cycle(2, 3); model_accept(2, 3);
    req_cycle(3, 4); exp_ovr = 1'b1;
    req_end();
    chk("overrun_set", o_overrun, 1'b1);
    wait_idle();
    chk("overrun_done_literal", o_ifm_buf_done, 4'b0111);
    check_idle_state("overrun");

    // Alternating valid into buffer 3
    toggle_mode = 1'b1;
    req_cycle(3, 0); model_accept(3, 0);
    req_end();
    wait_idle();
    toggle_mode = 1'b0;
    check_idle_state("toggle");

    // Re-request buffer 0 while its flag is set
    req_cycle(0, 2); model_accept(0, 2);
    req_end();
    chk("rereq_done0_cleared", o_ifm_buf_done[0], 1'b0);
    bad = 0; n = 0;
    while (o_busy && n < 500) begin
      if (o_ifm_buf_done[0]) bad++;
      @(negedge clk); n++;
    end
    chk("rereq_done0_low_while_busy", bad, 0);
    wait_idle();
    check_idle_state("rereq");

    // Zero-size row: no burst, flag after one cycle in the done state
    q_width = 8'd0;
    req_cycle(2, 5); model_accept(2, 5);
    req_end();
    chk("degenerate_no_req", {o_rd_req, o_ifm_buf_done[2]}, 2'b00);
    @(negedge clk);
    chk("degenerate_done", o_ifm_buf_done[2], 1'b1);
    wait_idle();
    check_idle_state("degenerate");

    // Randomized loads, including occasional frame restarts and pairs
    for (int it = 0; it < 24; it++) begin
      int sel;
      int id;
      if ($urandom_range(0, 1) == 1) begin
        q_width     = 8'($urandom_range(0, 5));
        q_channel   = 6'($urandom_range(1, 3));
        q_base_addr = $urandom & 32'h0FFF_FFF0;
      end
      sel = $urandom_range(0, 3);
      id  = $urandom_range(0, 3);
      if (sel == 0) pulse_start();
      else if (sel == 3) begin
        int id2;
        int r1;
        int r2;
        id2 = $urandom_range(0, 3);
        r1  = $urandom_range(0, 255);
        r2  = $urandom_range(0, 255);
        req_cycle(id, r1);  model_accept(id, r1);
        req_cycle(id2, r2); model_accept(id2, r2);
        req_end();
      end else begin
        int r1;
        r1 = $urandom_range(0, 255);
        req_cycle(id, r1); model_accept(id, r1);
        req_end();
      end
      wait_idle();
      check_idle_state("random");
    end

    // Reset in the middle of a transfer, then a clean restart
    q_width = 8'd4; q_channel = 6'd2; q_base_addr = 32'h200;
    req_cycle(2, 0); model_accept(2, 0);
    req_end();
    n = 0;
    while (!(o_buf_we[2] && o_buf_addr == 12'd3) && n < 200) begin @(negedge clk); #2; n++; end
    chk("midxfer_beat3_seen", n < 200, 1'b1);
    rstn = 1'b0;
    #1;
    chk("midxfer_reset_outputs",
        {o_rd_req, o_buf_we, o_ifm_buf_done, o_busy, o_overrun, o_rd_ready, o_rd_addr}, '0);
    exp_rd.delete(); exp_wr.delete(); exp_done = '0; exp_ovr = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_held_no_write", o_buf_we, 4'b0000);
    rstn = 1'b1;
    pulse_start();
    wait_idle();
    chk("restart_done_literal", o_ifm_buf_done, 4'b0001);
    check_idle_state("restart");

    chk("rd_queue_drained", exp_rd.size(), 0);
    chk("wr_queue_drained", exp_wr.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
